// File: rtl/alu_res_fifo_if.sv
// Handshake bundle between the ALU result port, the result FIFO and its consumer.
// The fifo modport is the FIFO side; the user modport is the ALU-plus-consumer side.
interface alu_res_fifo_if #(
  parameter int WIDTH = 64,
  parameter int AW    = 2
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [AW:0]      count;
  logic             full;
  logic             empty;

  modport fifo (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, count, full, empty
  );

  modport user (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, count, full, empty
  );
endinterface

// File: rtl/alu_res_fifo.sv
// First-word-fall-through result FIFO behind the 64-bit ALU.
// It has a synchronous flush for pipeline redirects and reports its occupancy.
module alu_res_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        flush,
  alu_res_fifo_if.fifo f
);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [AW-1:0]               wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]               rd_ptr_q, rd_ptr_d;
  logic [AW:0]                 count_q, count_d;
  logic                        full, empty, push, pop;

  // Status comes only from registered state, so in_ready has no path from out_ready.
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = f.in_valid && !full && !flush;
  assign pop   = !empty && f.out_ready && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = f.in_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // The storage is left unreset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign f.in_ready  = !full;
  assign f.out_valid = !empty;
  assign f.out_data  = empty ? '0 : mem_q[rd_ptr_q];
  assign f.count     = count_q;
  assign f.full      = full;
  assign f.empty     = empty;

endmodule

// File: tb/tb_alu_res_fifo.sv
// Bench for alu_res_fifo: a queue model checked every cycle, plus directed vectors
// with hand-computed expectations.
module tb_alu_res_fifo;
  localparam int WIDTH = 64;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic clk = 1'b0;
  logic rstn;
  logic flush;

  alu_res_fifo_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

  alu_res_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk   (clk),
    .rstn  (rstn),
    .flush (flush),
    .f     (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: an ordered list of the stored words.
  logic [WIDTH-1:0] q[$];

  always @(negedge rstn) q.delete();

  always @(posedge clk) begin
    if (rstn === 1'b1) begin
      if (flush) q.delete();
      else begin
        bit do_pop, do_push;
        do_pop  = (q.size() > 0) && bus.out_ready;
        do_push = bus.in_valid && (q.size() < DEPTH);
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back(bus.in_data);
      end
    end
  end

  // Every-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    logic [WIDTH-1:0] exp_data;
    exp_data = (q.size() > 0) ? q[0] : '0;
    chk("m_count",     64'(bus.count),     64'(q.size()));
    chk("m_empty",     64'(bus.empty),     64'(q.size() == 0));
    chk("m_full",      64'(bus.full),      64'(q.size() == DEPTH));
    chk("m_in_ready",  64'(bus.in_ready),  64'(q.size() != DEPTH));
    chk("m_out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
    chk("m_out_data",  64'(bus.out_data),  64'(exp_data));
  end

  // Applies inputs for one edge, then returns just after the following falling edge.
  task automatic step(input logic v, input logic [63:0] d, input logic r, input logic fl);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = r;
    flush         = fl;
    @(negedge clk);
    #1;
  endtask

  initial begin
    int exp_next;
    rstn          = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1 rstn = 1'b1;
    step(0, 0, 0, 0);
    chk("idle_count", 64'(bus.count), 0);
    chk("idle_empty", 64'(bus.empty), 1);
    chk("idle_full", 64'(bus.full), 0);
    chk("idle_in_ready", 64'(bus.in_ready), 1);
    chk("idle_out_valid", 64'(bus.out_valid), 0);
    chk("idle_out_data", bus.out_data, 0);

    // Fill with out_ready low.
    step(1, 64'h11, 0, 0);
    chk("fill1_count", 64'(bus.count), 1);
    chk("fill1_head", bus.out_data, 64'h11);
    step(1, 64'h22, 0, 0);
    chk("fill2_count", 64'(bus.count), 2);
    step(1, 64'h33, 0, 0);
    chk("fill3_count", 64'(bus.count), 3);
    step(1, 64'h44, 0, 0);
    chk("fill4_count", 64'(bus.count), 4);
    chk("fill4_full", 64'(bus.full), 1);
    chk("fill4_in_ready", 64'(bus.in_ready), 0);
    chk("fill4_head", bus.out_data, 64'h11);

    // Drain.
    chk("drain0", bus.out_data, 64'h11);
    step(0, 0, 1, 0);
    chk("drain1", bus.out_data, 64'h22);
    step(0, 0, 1, 0);
    chk("drain2", bus.out_data, 64'h33);
    step(0, 0, 1, 0);
    chk("drain3", bus.out_data, 64'h44);
    step(0, 0, 1, 0);
    chk("drain_empty", 64'(bus.empty), 1);
    chk("drain_out_data", bus.out_data, 0);

    // Simultaneous push and pop at count 2.
    step(1, 64'hA, 0, 0);
    step(1, 64'hC, 0, 0);
    chk("sim_setup_head", bus.out_data, 64'hA);
    step(1, 64'hB, 1, 0);
    chk("sim_count", 64'(bus.count), 2);
    chk("sim_head", bus.out_data, 64'hC);
    step(0, 0, 1, 0);
    chk("sim_tail", bus.out_data, 64'hB);
    step(0, 0, 1, 0);
    chk("sim_empty", 64'(bus.empty), 1);

    // Full with both sides active: pop only, push lands next edge.
    for (int i = 1; i <= 4; i++) step(1, 64'(i), 0, 0);
    chk("fb_full", 64'(bus.count), 4);
    step(1, 64'h55, 1, 0);
    chk("fb_count3", 64'(bus.count), 3);
    chk("fb_in_ready", 64'(bus.in_ready), 1);
    chk("fb_head", bus.out_data, 64'h2);
    step(1, 64'h55, 0, 0);
    chk("fb_count4", 64'(bus.count), 4);
    chk("fb_d2", bus.out_data, 64'h2);
    step(0, 0, 1, 0);
    chk("fb_d3", bus.out_data, 64'h3);
    step(0, 0, 1, 0);
    chk("fb_d4", bus.out_data, 64'h4);
    step(0, 0, 1, 0);
    chk("fb_d55", bus.out_data, 64'h55);
    step(0, 0, 1, 0);
    chk("fb_empty", 64'(bus.empty), 1);

    // Wrap-around streaming of 1..10.
    exp_next = 1;
    step(1, 64'h1, 0, 0);
    step(1, 64'h2, 0, 0);
    for (int k = 3; k <= 10; k++) begin
      chk("wrap_order", bus.out_data, 64'(exp_next));
      step(1, 64'(k), 1, 0);
      exp_next++;
    end
    while (exp_next <= 10) begin
      chk("wrap_order", bus.out_data, 64'(exp_next));
      step(0, 0, 1, 0);
      exp_next++;
    end
    chk("wrap_empty", 64'(bus.empty), 1);

    // Flush with a concurrent push and pop.
    step(1, 64'h1, 0, 0);
    step(1, 64'h2, 0, 0);
    step(1, 64'h3, 0, 0);
    chk("fl_count3", 64'(bus.count), 3);
    step(1, 64'h99, 1, 1);
    chk("fl_count", 64'(bus.count), 0);
    chk("fl_empty", 64'(bus.empty), 1);
    chk("fl_in_ready", 64'(bus.in_ready), 1);
    step(0, 0, 1, 0);
    chk("fl_no99", 64'(bus.out_valid), 0);

    // Async reset between edges.
    step(1, 64'h7, 0, 0);
    step(1, 64'h8, 0, 0);
    step(0, 0, 0, 0);
    chk("ar_count2", 64'(bus.count), 2);
    #1 rstn = 1'b0;
    #1;
    chk("ar_empty", 64'(bus.empty), 1);
    chk("ar_out_valid", 64'(bus.out_valid), 0);
    chk("ar_count", 64'(bus.count), 0);
    chk("ar_out_data", bus.out_data, 0);
    @(negedge clk);
    #1 rstn = 1'b1;
    step(1, 64'hDD, 0, 0);
    chk("post_rst_push", bus.out_data, 64'hDD);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/alu_res_fifo.md
Name: alu_res_fifo

Overview:
- Result buffer directly downstream of the 64-bit ALU.
- Its in_* side connects straight to the ALU's res/out_valid/out_ready handshake.
- Gives the ALU DEPTH entries of elasticity, so the ALU's in_ready stays high while the consumer stalls.
- First-word-fall-through FIFO with occupancy reporting and a synchronous flush, used on pipeline redirect.

Parameters:
- WIDTH, 64, data width of one result entry.
- DEPTH, 4, number of entries; must be a power of 2 and at least 2.
- AW, 2, pointer width; must equal log2(DEPTH).

Ports:
- clk  input  1  clock; everything is sampled on the rising edge.
- rstn  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear of all entries; active high.
- in_data  input  WIDTH  result from the ALU res output.
- in_valid  input  1  ALU out_valid.
- in_ready  output  1  goes to ALU out_ready; equals ~full.
- out_data  output  WIDTH  head entry; reads 0 when empty.
- out_valid  output  1  head entry present; equals ~empty.
- out_ready  input  1  consumer accepts the head entry.
- count  output  AW+1  number of occupied entries, 0..DEPTH.
- full  output  1  asserted when count == DEPTH.
- empty  output  1  asserted when count == 0.

Behaviour:
- Reset, asynchronous on rstn low:
  - wr_ptr, rd_ptr and count are cleared to 0.
  - Outputs: full=0, empty=1, out_valid=0, in_ready=1, out_data=0.
  - Storage array is not reset.
  - Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.
- Push:
  - Occurs on the edge where in_valid && in_ready && !flush.
  - Writes mem[wr_ptr] and sets wr_ptr <= wr_ptr+1, wrapping modulo DEPTH.
- Pop:
  - Occurs on the edge where out_valid && out_ready && !flush.
  - Sets rd_ptr <= rd_ptr+1, wrapping modulo DEPTH.
- count update on each edge:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged when push and pop happen together.
- Latency: a word pushed at edge N is visible on out_data, with out_valid=1, in the cycle after edge N. There is no same-cycle bypass.
- FWFT output: out_data = mem[rd_ptr] combinationally while !empty, and 0 while empty.
- in_ready:
  - in_ready = ~full; it depends only on registered state.
  - It has no combinational path from out_ready, so a pop cannot make room for a push in the same cycle when full.
- Boundary cases:
  - Full, with in_valid=1 and out_ready=1: pop only; count goes DEPTH to DEPTH-1; the ALU holds its result until the next cycle.
  - Empty: out_valid=0, so a pop cannot occur and out_ready is ignored. A push goes 0 to 1.
  - Pointer wrap: after DEPTH pushes, wr_ptr returns to 0. Ordering stays strictly FIFO across the wrap.
- flush:
  - On an edge with flush=1, wr_ptr, rd_ptr and count are cleared.
  - A concurrent push or pop is discarded and has no effect on state.
  - The cycle after the flush edge reads empty=1 and in_ready=1.
- in_data is sampled only on a push edge. in_data/in_valid stability while in_ready=0 is the ALU's responsibility; the FIFO does not check it.
- No overflow or underflow is possible by construction. No error outputs are provided.

Test Plan:
- Reset then idle: rstn low for 2 cycles, then high with no traffic -> count=0, empty=1, full=0, in_ready=1, out_valid=0, out_data=0.
- Fill and drain, DEPTH=4, out_ready=0:
  - Push 0x11, 0x22, 0x33, 0x44 on consecutive edges -> count 1,2,3,4; full=1 and in_ready=0 after the 4th edge; out_data=0x11 from the cycle after the 1st push.
  - Then out_ready=1 -> out_data sequence 0x11, 0x22, 0x33, 0x44; empty=1 after the 4th pop.
- Simultaneous push/pop:
  - Setup: count=2, head=0xA.
  - Stimulus: push 0xB and pop on the same edge.
  - Required: count stays 2; out_data becomes the 2nd entry; 0xB lands at the tail.
- Full with both sides active: count=4, in_valid=1 with 0x55, out_ready=1 -> first edge pops only (count=3, in_ready=1); next edge with out_ready=0 pushes 0x55 -> count=4.
- Wrap-around: push/pop 10 words 0x1..0xA, keeping count at or below 3 -> output order exactly 0x1..0xA while both pointers wrap past 3->0.
- Flush and async reset:
  - count=3, flush=1 together with in_valid=1 (0x99) -> next cycle count=0, empty=1; 0x99 is never output.
  - Separately, drop rstn between clock edges with count=2 -> empty=1 and out_valid=0 immediately, before the next rising edge.
